// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
// Holds the FSM state encoding and settle/width constants.
package addsub_pkg;

    localparam int NIBBLE_W     = 4;
    localparam int GUARD_CYCLES = 2;

    typedef enum logic [2:0] {
        GUARD,
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/addsub_wdog.sv
// Handshake watchdog: counts enabled cycles, pulses expire on the
// TIMEOUT-th consecutive enabled cycle; clr restarts the count.
module addsub_wdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // count enabled cycles, restart whenever cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // expire on the cycle the count reaches TIMEOUT
    always_comb begin
        expire = en && !clr && (cnt == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/addsub_seq.sv
// Runs a wide add/sub as a carry chain of 4-bit peripheral operations.
// Optional signed-overflow output is enabled by defining ADDSUB_OVF_EN.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [4*NIBBLES-1:0]  op_a,
    input  logic [4*NIBBLES-1:0]  op_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [4*NIBBLES-1:0]  result,
    output logic                  cout,
`ifdef ADDSUB_OVF_EN
    output logic                  ovf,
`endif
    output logic                  u_cs,
    output logic [NIBBLE_W-1:0]   u_a,
    output logic [NIBBLE_W-1:0]   u_b,
    output logic                  u_cin,
    output logic                  u_sub,
    input  logic [NIBBLE_W-1:0]   u_sum,
    input  logic                  u_cout,
    input  logic                  u_rdy
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t         state, state_n;
    logic [1:0]     gcnt;
    logic [W-1:0]   a_q, b_q;
    logic           carry;
    logic [IW-1:0]  idx;
    logic           last;
    logic           expire;

    assign last = (idx == IW'(NIBBLES - 1));

    addsub_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != WAIT),
        .en     (state == WAIT && u_rdy),
        .expire (expire)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= GUARD;
        else     state <= state_n;
    end

    // next-state and handshake outputs
    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        u_cs    = 1'b0;
        unique case (state)
            GUARD: begin
                if (gcnt == 2'(GUARD_CYCLES - 1)) state_n = IDLE;
            end
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = ISSUE;
            end
            ISSUE: begin
                u_cs    = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (!u_rdy) begin
                    state_n = CAPTURE;
                end else if (expire) begin
                    err     = 1'b1;
                    state_n = IDLE;
                end
            end
            CAPTURE: begin
                if (u_rdy) state_n = last ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = GUARD;
        endcase
    end

    // peripheral operands come straight from the latched words
    always_comb begin
        u_a   = a_q[idx*NIBBLE_W +: NIBBLE_W];
        u_b   = b_q[idx*NIBBLE_W +: NIBBLE_W];
        u_cin = carry;
        u_sub = 1'b0;
    end

    // guard settle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                gcnt <= '0;
        else if (state == GUARD) gcnt <= gcnt + 1'b1;
        else                    gcnt <= '0;
    end

    // operand latch, nibble capture and carry chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q   <= op_a;
            b_q   <= op_sub ? ~op_b : op_b;
            carry <= op_sub;
            idx   <= '0;
        end else if (state == CAPTURE && u_rdy) begin
            result[idx*NIBBLE_W +: NIBBLE_W] <= u_sum;
            carry <= u_cout;
            if (last) cout <= u_cout;
            else      idx  <= idx + 1'b1;
        end
    end

`ifdef ADDSUB_OVF_EN
    // signed overflow, settled as the top nibble lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf <= 1'b0;
        end else if (state == CAPTURE && u_rdy && last) begin
            ovf <= (a_q[W-1] == b_q[W-1]) && (u_sum[NIBBLE_W-1] != a_q[W-1]);
        end
    end
`endif

endmodule
